axi_mem_responder: RTL and testbench
====================================

Name: axi_mem_responder

Overview:
- AXI4 subordinate memory model that sits at the memory-side end of the cache's AXI initiator port.
- Serves INCR read and write bursts from an internal word-addressed RAM.
- Used as the downstream responder in cache integration benches. It is also synthesizable, so it can serve as an on-chip scratch memory.
- Handles one transaction at a time, with programmable read latency.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, data width in bits; a power of two, at least 8.
- ID_W, 4, AXI ID width.
- MEM_DEPTH, 256, RAM depth in DATA_W words; a power of two.
- RD_LATENCY, 2, cycles from AR handshake to first rvalid; must be at least 1.

Ports:
- clk in 1: clock.
- rst_n in 1: asynchronous active-low reset.
- awid in ID_W; awaddr in ADDR_W; awlen in 8; awvalid in 1; awready out 1: write address channel.
- wdata in DATA_W; wstrb in DATA_W/8; wlast in 1; wvalid in 1; wready out 1: write data channel.
- bid out ID_W; bresp out 2; bvalid out 1; bready in 1: write response channel.
- arid in ID_W; araddr in ADDR_W; arlen in 8; arvalid in 1; arready out 1: read address channel.
- rid out ID_W; rdata out DATA_W; rresp out 2; rlast out 1; rvalid out 1; rready in 1: read data channel.

Behaviour:
- Reset: asynchronous, active-low.
  - While rst_n is low: state IDLE; all valid and ready outputs 0; bresp, rresp, rdata, rid, bid and rlast are 0.
  - RAM contents are not reset.
  - Reset mid-burst abandons the transaction immediately; no partial response is issued afterwards.
- FSM states: IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP.
- IDLE:
  - arready=1.
  - awready=1 only when arvalid=0, so reads have fixed priority. Simultaneous arvalid and awvalid: the read is accepted and the write waits.
  - AR handshake: latch arid, word index, arlen; go to RD_WAIT.
  - AW handshake: latch awid, word index, awlen; go to WR_DATA.
- RD_WAIT: counts RD_LATENCY-1 cycles, then goes to RD_DATA. For an AR handshake at edge T, rvalid first rises after edge T+RD_LATENCY.
- RD_DATA:
  - One beat per cycle while rready=1.
  - rdata, rresp, rid and rlast are held stable while rvalid=1 and rready=0.
  - rlast=1 on beat arlen.
  - After the last handshake: rvalid drops and state returns to IDLE. A new AR is not accepted in that same cycle.
- WR_DATA:
  - wready=1.
  - Each W handshake writes the bytes enabled by wstrb at the current index, then increments the index.
  - After beat awlen is accepted, go to WR_RESP.
  - Beat count comes from awlen only. wlast high on an earlier beat, or low on the final beat, sets a protocol-error flag; termination still follows awlen.
- WR_RESP: bvalid=1 with the latched bid. On bready, go to IDLE.
- Addressing:
  - Word index = addr >> log2(DATA_W/8); low byte-offset bits are ignored.
  - Index increments by 1 per beat (INCR only); awburst, awsize and the AR equivalents are not ported.
  - A beat whose word index is at or above MEM_DEPTH is out of range:
    - read beat: rdata=0, rresp=SLVERR;
    - write beat: the write is dropped and an error flag is set.
  - Burst indexes are computed at full ADDR_W width; they do not wrap modulo MEM_DEPTH.
- Response codes:
  - bresp = SLVERR if any beat of the burst was out of range or the protocol-error flag is set; otherwise OKAY.
  - rresp is evaluated per beat.
- RAM is synchronous-read. The read pipeline prefetches the next beat so that back-to-back beats run with no bubble while rready is held high.

Decomposition:
- Shared package axi_cache_pkg holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the responder state enum;
  - the AXI len width constant.
- One sub-module, axi_mem_ram: single-port, byte-write-enable, synchronous-read RAM (DATA_W, MEM_DEPTH).

Test Plan:
- Single write: AW addr 0x10, len 0; W 0xDEADBEEF, strb 0xF, wlast 1 -> wready in the cycle after the AW handshake; bvalid with bid = awid, bresp OKAY.
- Read-back with latency: AR addr 0x10, len 0, RD_LATENCY 2 -> rvalid rises two edges after the AR handshake; rdata 0xDEADBEEF, rlast 1, rresp OKAY.
- 4-beat burst with backpressure: write 4 beats at 0x0 (values 1..4), read len 3 with rready toggling 1,0,1,0 -> data 1..4 in order; outputs held stable while stalled; rlast on beat 3 only.
- Byte strobes: write 0xAABBCCDD with wstrb 0x5 over a word holding 0 -> read returns 0x00BB00DD.
- Out of range (MEM_DEPTH 256, DATA_W 32): read at 0x3FC with len 1 -> beat 0 OKAY, beat 1 rdata 0 and SLVERR. Write len 0 with wlast 0 -> bresp SLVERR.
- Simultaneous arvalid and awvalid in IDLE -> read served first and awready held 0 until the read completes. Then assert rst_n low mid-burst -> rvalid=0 and all readys 0 immediately; IDLE after release.

Source files
------------

// File: rtl/axi_cache_pkg.sv
// Shared definitions for the cache-side AXI blocks.
// Holds the AXI response codes, the burst length width and the state
// encoding of the memory responder FSM.
package axi_cache_pkg;

  localparam int AXI_LEN_W = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Responder FSM encoding, kept as plain constants so older tools and
  // netlist viewers show the raw state values.
  typedef logic [2:0] resp_state_t;

  localparam resp_state_t ST_IDLE    = 3'd0;
  localparam resp_state_t ST_RD_WAIT = 3'd1;
  localparam resp_state_t ST_RD_DATA = 3'd2;
  localparam resp_state_t ST_WR_DATA = 3'd3;
  localparam resp_state_t ST_WR_RESP = 3'd4;

endpackage

// File: rtl/axi_mem_ram.sv
// Single-port RAM with per-byte write enables and a registered read port.
// Ports:
//   clk   - clock
//   addr  - word address, shared by read and write
//   we    - one write enable per byte lane
//   wdata - write data
//   rdata - contents of mem[addr] sampled at the previous clock edge
//           (read-before-write when the same word is written)
module axi_mem_ram #(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 256,
  parameter int AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_W/8-1:0]   we,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Contents are deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_W / 8; b++) begin
      if (we[b]) begin
        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate memory model serving one INCR burst at a time from an
// internal word-addressed RAM, with a programmable read latency.
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   aw*  (awid/awaddr/awlen/awvalid/awready)        - write address channel
//   w*   (wdata/wstrb/wlast/wvalid/wready)          - write data channel
//   b*   (bid/bresp/bvalid/bready)                  - write response channel
//   ar*  (arid/araddr/arlen/arvalid/arready)        - read address channel
//   r*   (rid/rdata/rresp/rlast/rvalid/rready)      - read data channel
module axi_mem_responder
  import axi_cache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ID_W       = 4,
  parameter int MEM_DEPTH  = 256,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [ID_W-1:0]       awid,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic [7:0]            awlen,
  input  logic                  awvalid,
  output logic                  awready,

  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,

  output logic [ID_W-1:0]       bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,

  input  logic [ID_W-1:0]       arid,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic [7:0]            arlen,
  input  logic                  arvalid,
  output logic                  arready,

  output logic [ID_W-1:0]       rid,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int RAM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int LAT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(MEM_DEPTH);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(RD_LATENCY - 1);

  resp_state_t          state;
  logic [ID_W-1:0]      id_q;
  logic [IDX_W-1:0]     idx_q;
  logic [AXI_LEN_W-1:0] len_q;
  logic [AXI_LEN_W-1:0] beat_q;
  logic [LAT_W-1:0]     lat_q;
  logic                 err_q;

  logic                 ar_hs;
  logic                 aw_hs;
  logic                 idx_ok;
  logic                 last_beat;
  logic [RAM_AW-1:0]    ram_addr;
  logic [STRB_W-1:0]    ram_we;
  logic [DATA_W-1:0]    ram_rdata;

  // The byte-offset bits of the addresses never select anything.
  if (OFF_W > 0) begin : g_offset
    logic unused_addr_bits;
    assign unused_addr_bits = ^{awaddr[OFF_W-1:0], araddr[OFF_W-1:0]};
  end

  // Readys are qualified with rst_n so they are low throughout reset.
  // Reads have fixed priority: awready is withheld while arvalid is high.
  assign arready = rst_n && (state == ST_IDLE);
  assign awready = rst_n && (state == ST_IDLE) && !arvalid;
  assign wready  = (state == ST_WR_DATA);
  assign rvalid  = (state == ST_RD_DATA);
  assign bvalid  = (state == ST_WR_RESP);

  assign ar_hs = arvalid && arready;
  assign aw_hs = awvalid && awready;

  // Out-of-range is judged on the full-width index so bursts never wrap.
  assign idx_ok    = (idx_q < DEPTH_IDX);
  assign last_beat = (beat_q == len_q);

  // Read outputs are derived from registers that only move on a handshake
  // plus the RAM output, whose address is held during a stall, so they
  // stay stable while rready is low.
  assign rid   = rvalid ? id_q : '0;
  assign rlast = rvalid && last_beat;
  assign rresp = (rvalid && !idx_ok) ? RESP_SLVERR : RESP_OKAY;
  assign rdata = (rvalid && idx_ok) ? ram_rdata : '0;

  assign bid   = bvalid ? id_q : '0;
  assign bresp = (bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;

  // On an R handshake the RAM is already pointed at the following word,
  // so the next beat is available right after the edge with no bubble.
  assign ram_addr = (rvalid && rready) ? idx_q[RAM_AW-1:0] + RAM_AW'(1)
                                       : idx_q[RAM_AW-1:0];

  // Out-of-range write beats are dropped by suppressing every lane.
  assign ram_we = (wready && wvalid && idx_ok) ? wstrb : '0;

  axi_mem_ram #(
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH),
    .AW        (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (wdata),
    .rdata (ram_rdata)
  );

  // Transaction FSM. RD_WAIT lasts RD_LATENCY cycles in total; during it
  // the RAM is already addressed with beat 0 so data is ready on entry
  // to RD_DATA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      id_q   <= '0;
      idx_q  <= '0;
      len_q  <= '0;
      beat_q <= '0;
      lat_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ar_hs) begin
            id_q   <= arid;
            idx_q  <= araddr[ADDR_W-1:OFF_W];
            len_q  <= arlen;
            beat_q <= '0;
            lat_q  <= '0;
            state  <= ST_RD_WAIT;
          end else if (aw_hs) begin
            id_q   <= awid;
            idx_q  <= awaddr[ADDR_W-1:OFF_W];
            len_q  <= awlen;
            beat_q <= '0;
            err_q  <= 1'b0;
            state  <= ST_WR_DATA;
          end
        end
        ST_RD_WAIT: begin
          if (lat_q == LAT_LAST) begin
            state <= ST_RD_DATA;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        ST_RD_DATA: begin
          if (rready) begin
            if (last_beat) begin
              state <= ST_IDLE;
            end else begin
              idx_q  <= idx_q + IDX_W'(1);
              beat_q <= beat_q + AXI_LEN_W'(1);
            end
          end
        end
        ST_WR_DATA: begin
          if (wvalid) begin
            // awlen alone decides the burst end; a misplaced wlast only
            // poisons the response.
            if (!idx_ok || (wlast != last_beat)) begin
              err_q <= 1'b1;
            end
            if (last_beat) begin
              state <= ST_WR_RESP;
            end else begin
              idx_q  <= idx_q + IDX_W'(1);
              beat_q <= beat_q + AXI_LEN_W'(1);
            end
          end
        end
        ST_WR_RESP: begin
          if (bready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder with default parameters
// (32-bit data, 256 words, read latency 2). Inputs are driven and outputs
// sampled on the falling edge.
module tb_axi_mem_responder;
  import axi_cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int total = 0;
  int passed = 0;

  axi_mem_responder #(
    .ADDR_W(32), .DATA_W(32), .ID_W(4), .MEM_DEPTH(256), .RD_LATENCY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  exp_bresp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } vec_t;

  vec_t vecs[6];

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // All helpers start and end on a falling edge.
  task automatic apply_aw(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    int n = 0;
    awaddr = addr; awid = id; awlen = len; awvalid = 1'b1;
    #1;
    while (!awready && n < 100) begin @(negedge clk); n++; end
    check_output("aw_accept", awready, 1'b1);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    while (!wready && n < 100) begin @(negedge clk); n++; end
    check_output("w_accept", wready, 1'b1);
    @(negedge clk);
    wvalid = 1'b0;
  endtask

  task automatic check_b(input string name, input logic [3:0] id, input logic [1:0] resp);
    int n = 0;
    bready = 1'b1;
    while (!bvalid && n < 100) begin @(negedge clk); n++; end
    check_output({name, "_bvalid"}, bvalid, 1'b1);
    check_output({name, "_bid"}, bid, id);
    check_output({name, "_bresp"}, bresp, resp);
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic apply_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
    int n = 0;
    araddr = addr; arid = id; arlen = len; arvalid = 1'b1;
    #1;
    while (!arready && n < 100) begin @(negedge clk); n++; end
    check_output("ar_accept", arready, 1'b1);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic get_r(input string name, input logic [3:0] id, input logic [31:0] data,
                       input logic [1:0] resp, input logic last);
    int n = 0;
    rready = 1'b1;
    while (!rvalid && n < 100) begin @(negedge clk); n++; end
    check_output({name, "_rvalid"}, rvalid, 1'b1);
    check_output({name, "_rid"}, rid, id);
    check_output({name, "_rdata"}, rdata, data);
    check_output({name, "_rresp"}, rresp, resp);
    check_output({name, "_rlast"}, rlast, last);
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int beat;
    int n;

    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;

    // Single-beat vectors: write then read back; the last one is out of range.
    vecs[0] = '{32'h10,  32'hDEADBEEF, 4'hF, RESP_OKAY,   32'hDEADBEEF, RESP_OKAY};
    vecs[1] = '{32'h20,  32'h00000000, 4'hF, RESP_OKAY,   32'h00000000, RESP_OKAY};
    vecs[2] = '{32'h20,  32'hAABBCCDD, 4'h5, RESP_OKAY,   32'h00BB00DD, RESP_OKAY};
    vecs[3] = '{32'h22,  32'h11223344, 4'hA, RESP_OKAY,   32'h11BB33DD, RESP_OKAY};
    vecs[4] = '{32'h3FC, 32'h12345678, 4'hF, RESP_OKAY,   32'h12345678, RESP_OKAY};
    vecs[5] = '{32'h400, 32'hCAFEF00D, 4'hF, RESP_SLVERR, 32'h00000000, RESP_SLVERR};

    repeat (3) @(negedge clk);
    check_output("rst_arready", arready, 1'b0);
    check_output("rst_awready", awready, 1'b0);
    check_output("rst_wready", wready, 1'b0);
    check_output("rst_rvalid", rvalid, 1'b0);
    check_output("rst_bvalid", bvalid, 1'b0);
    check_output("rst_rdata", rdata, 32'h0);
    check_output("rst_rlast", rlast, 1'b0);
    check_output("rst_bresp", bresp, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("idle_arready", arready, 1'b1);
    check_output("idle_awready", awready, 1'b1);

    for (int i = 0; i < 6; i++) begin
      apply_aw(vecs[i].addr, 4'(i + 1), 8'd0);
      check_output($sformatf("vec%0d_wready_after_aw", i), wready, 1'b1);
      apply_stimulus(vecs[i].wdata, vecs[i].wstrb, 1'b1);
      check_b($sformatf("vec%0d", i), 4'(i + 1), vecs[i].exp_bresp);
      apply_ar(vecs[i].addr, 4'(i + 8), 8'd0);
      check_output($sformatf("vec%0d_rvalid_t1", i), rvalid, 1'b0);
      @(negedge clk);
      check_output($sformatf("vec%0d_rvalid_t2", i), rvalid, 1'b0);
      @(negedge clk);
      check_output($sformatf("vec%0d_rvalid_t3", i), rvalid, 1'b1);
      get_r($sformatf("vec%0d", i), 4'(i + 8), vecs[i].exp_rdata, vecs[i].exp_rresp, 1'b1);
      check_output($sformatf("vec%0d_rvalid_drop", i), rvalid, 1'b0);
    end

    // Four-beat burst written at 0, read back with rready toggling.
    apply_aw(32'h0, 4'd3, 8'd3);
    apply_stimulus(32'd1, 4'hF, 1'b0);
    apply_stimulus(32'd2, 4'hF, 1'b0);
    apply_stimulus(32'd3, 4'hF, 1'b0);
    apply_stimulus(32'd4, 4'hF, 1'b1);
    check_b("burst_wr", 4'd3, RESP_OKAY);
    apply_ar(32'h0, 4'd4, 8'd3);
    beat = 0; n = 0;
    while (beat < 4 && n < 100) begin
      rready = (n % 2 == 0);
      if (rvalid) begin
        check_output($sformatf("burst_rdata_b%0d", beat), rdata, 32'(beat + 1));
        check_output($sformatf("burst_rlast_b%0d", beat), rlast, (beat == 3));
        check_output($sformatf("burst_rresp_b%0d", beat), rresp, RESP_OKAY);
        check_output($sformatf("burst_rid_b%0d", beat), rid, 4'd4);
        if (rready) beat++;
      end
      @(negedge clk);
      n++;
    end
    rready = 1'b0;
    check_output("burst_beats", beat, 4);
    check_output("burst_rvalid_drop", rvalid, 1'b0);

    // Read crossing the top of memory: second beat is out of range.
    apply_ar(32'h3FC, 4'd2, 8'd1);
    get_r("oor_b0", 4'd2, 32'h12345678, RESP_OKAY, 1'b0);
    check_output("oor_no_bubble", rvalid, 1'b1);
    get_r("oor_b1", 4'd2, 32'h0, RESP_SLVERR, 1'b1);
    check_output("oor_rvalid_drop", rvalid, 1'b0);

    // wlast low on the only beat, then wlast high too early.
    apply_aw(32'h30, 4'd7, 8'd0);
    apply_stimulus(32'h55, 4'hF, 1'b0);
    check_b("wlast_low", 4'd7, RESP_SLVERR);
    apply_aw(32'h34, 4'd8, 8'd1);
    apply_stimulus(32'h66, 4'hF, 1'b1);
    check_output("wlast_early_still_wdata", wready, 1'b1);
    apply_stimulus(32'h67, 4'hF, 1'b1);
    check_b("wlast_early", 4'd8, RESP_SLVERR);

    // Simultaneous AR and AW: read wins, write waits for it to finish.
    arid = 4'd5; araddr = 32'h0; arlen = 8'd3; arvalid = 1'b1;
    awid = 4'd6; awaddr = 32'h40; awlen = 8'd0; awvalid = 1'b1;
    #1;
    check_output("prio_arready", arready, 1'b1);
    check_output("prio_awready", awready, 1'b0);
    @(negedge clk);
    arvalid = 1'b0;
    rready = 1'b1;
    beat = 0; n = 0;
    while (beat < 4 && n < 100) begin
      check_output("prio_awready_held", awready, 1'b0);
      if (rvalid) begin
        check_output($sformatf("prio_rdata_b%0d", beat), rdata, 32'(beat + 1));
        beat++;
      end
      @(negedge clk);
      n++;
    end
    rready = 1'b0;
    check_output("prio_beats", beat, 4);
    check_output("prio_awready_after", awready, 1'b1);
    @(negedge clk);
    awvalid = 1'b0;
    check_output("prio_wready", wready, 1'b1);
    apply_stimulus(32'h77, 4'hF, 1'b1);
    check_b("prio_wr", 4'd6, RESP_OKAY);

    // Reset in the middle of a read burst.
    apply_ar(32'h0, 4'd9, 8'd3);
    get_r("rstmid_b0", 4'd9, 32'd1, RESP_OKAY, 1'b0);
    check_output("rstmid_pre_rvalid", rvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    check_output("rstmid_rvalid", rvalid, 1'b0);
    check_output("rstmid_arready", arready, 1'b0);
    check_output("rstmid_awready", awready, 1'b0);
    check_output("rstmid_wready", wready, 1'b0);
    check_output("rstmid_rdata", rdata, 32'h0);
    check_output("rstmid_rid", rid, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_output($sformatf("rstmid_no_resp_%0d", k), rvalid, 1'b0);
    end
    rready = 1'b0;
    check_output("rstmid_idle_arready", arready, 1'b1);

    // RAM contents survive reset.
    apply_ar(32'h10, 4'd1, 8'd0);
    get_r("post_rst", 4'd1, 32'hDEADBEEF, RESP_OKAY, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
